// File: rtl/p_serial_sub_12b_pkg.sv
// p_serial_sub_12b_pkg: shared state encoding and sizes for the bit-serial subtractor
package p_serial_sub_12b_pkg;
  localparam int W_DEF = 12;
  localparam int CW = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/p_fs.sv
// p_fs: one-bit full subtractor cell, the subtract counterpart of the full adder
module p_fs (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/p_serial_sub_12b.sv
// p_serial_sub_12b: LSB-first bit-serial subtractor, one bit per cycle, registered result and borrow
module p_serial_sub_12b
  import p_serial_sub_12b_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] d,
  output logic         borrow,
  output logic         busy,
  output logic         done
);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t state, nxt;
  logic [W-1:0] a, b, r;
  logic [CW-1:0] cnt;
  logic bi, diff, bo, last, busy_nx, done_nx;
  assign last = cnt == LAST;
  p_fs u_fs (
    .a (a[0]),
    .b (b[0]),
    .bi(bi),
    .d (diff),
    .bo(bo)
  );
  always_comb nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy_nx = nxt == RUN;
    done_nx = nxt == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      r      <= '0;
      bi     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      borrow <= 1'b0;
    end else if (state == RUN) begin
      a   <= a >> 1;
      b   <= b >> 1;
      r   <= {diff, r[W-1:1]};
      bi  <= bo;
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        d      <= {diff, r[W-1:1]};
        borrow <= bo;
      end
    end else if (start) begin
      a   <= x;
      b   <= y;
      bi  <= 1'b0;
      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_p_serial_sub_12b.sv
// tb_p_serial_sub_12b: directed vectors with hand-computed results for the serial subtractor
module tb_p_serial_sub_12b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic [11:0] d;
  logic borrow, busy, done;
  int pass_cnt = 0;
  int total = 0;
  logic [11:0] last_d = '0;
  p_serial_sub_12b #(.W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .d     (d),
    .borrow(borrow),
    .busy  (busy),
    .done  (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else pass_cnt++;
  endtask
  task automatic go(input logic [11:0] xv, input logic [11:0] yv);
    start = 1'b1;
    x = xv;
    y = yv;
  endtask
  task automatic watch(input string tag, input logic [11:0] ed, input logic eb, input int poke_k,
                       input logic [11:0] px, input logic [11:0] py, input bit chain);
    int busy_n, done_n, done_at;
    busy_n = 0;
    done_n = 0;
    done_at = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 6) chk({tag, "_hold"}, d, last_d);
      busy_n += int'(busy);
      if (done) begin
        done_n++;
        done_at = k;
      end
      start = k == poke_k;
      if (start) begin
        x = px;
        y = py;
      end
    end
    chk({tag, "_busy_cycles"}, busy_n, 12);
    chk({tag, "_done_at"}, done_at, 13);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_borrow"}, borrow, eb);
    last_d = ed;
    if (!chain) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
    end
  endtask
  initial begin
    #1;
    chk("rst_d", d, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    go(12'd5, 12'd3);
    watch("5m3", 12'h002, 1'b0, 0, '0, '0, 1'b0);
    go(12'd3, 12'd5);
    watch("3m5", 12'hFFE, 1'b1, 0, '0, '0, 1'b0);
    go(12'd0, 12'd1);
    watch("0m1", 12'hFFF, 1'b1, 0, '0, '0, 1'b0);
    go(12'hFFF, 12'hFFF);
    watch("fffmfff", 12'h000, 1'b0, 0, '0, '0, 1'b0);
    go(12'h800, 12'h000);
    watch("800m0", 12'h800, 1'b0, 0, '0, '0, 1'b0);
    go(12'd7, 12'd2);
    watch("ignore", 12'h005, 1'b0, 4, 12'd9, 12'd9, 1'b0);
    go(12'd5, 12'd3);
    watch("b2b_a", 12'h002, 1'b0, 13, 12'd7, 12'd2, 1'b1);
    watch("b2b_b", 12'h005, 1'b0, 0, '0, '0, 1'b0);
    go(12'd5, 12'd3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_d", d, 0);
    chk("abort_borrow", borrow, 0);
    begin
      int done_n;
      done_n = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        done_n += int'(done);
        if (k == 2) rst_n = 1'b1;
      end
      chk("abort_no_done", done_n, 0);
    end
    last_d = '0;
    go(12'd10, 12'd4);
    watch("10m4", 12'h006, 1'b0, 0, '0, '0, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
